// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor and the ALU sequencer.
// Holds the handshake FSM state encoding.
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor.
// Produces difference and borrow-out from a, b and borrow-in.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: result = a - b, one bit per clock.
// Valid/ready on both sides; outputs only change when entering DONE.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] result,
  output logic            borrow,
  output logic            overflow
);

  localparam int CW = $clog2(SIZE + 1);

  sub_state_t state;
  sub_state_t state_nxt;

  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] sa;
  logic [SIZE-1:0] sb;
  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] acc_nxt;
  logic            bor;
  logic            bor_nxt;
  logic            a_msb;
  logic            b_msb;
  logic            d;
  logic            last;
  logic            fire_in;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bor),
    .d    (d),
    .bout (bor_nxt)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign fire_in   = in_valid && in_ready;
  assign last      = (cnt == CW'(SIZE - 1));

  // New difference bit enters at the MSB.
  assign acc_nxt = (acc >> 1)
                 | (SIZE'(d) << (SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (fire_in) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      bor      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result   <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == S_IDLE && fire_in) begin
        sa    <= a;
        sb    <= b;
        acc   <= '0;
        bor   <= 1'b0;
        cnt   <= '0;
        a_msb <= a[SIZE-1];
        b_msb <= b[SIZE-1];
      end else if (state == S_RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        acc <= acc_nxt;
        bor <= bor_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          result   <= acc_nxt;
          borrow   <= bor_nxt;
          // The last difference bit is the result sign bit.
          overflow <= (a_msb != b_msb)
                   && (d != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at SIZE=8 and SIZE=1.
// Arithmetic reference model plus directed literal vectors.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ov8;
  logic       or8 = 1'b0;
  logic [7:0] r8;
  logic       bo8;
  logic       of8;

  logic iv1 = 1'b0;
  logic ir1;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic ov1;
  logic or1 = 1'b0;
  logic r1;
  logic bo1;
  logic of1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit         pend [2];
  int         rdy  [2];
  logic [7:0] er   [2];
  logic       eb   [2];
  logic       eo   [2];
  logic [7:0] vr   [2];
  logic       vb   [2];
  logic       vo   [2];

  always #5 clk = ~clk;

  serial_subtractor #(.SIZE(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .result    (r8),
    .borrow    (bo8),
    .overflow  (of8)
  );

  serial_subtractor #(.SIZE(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .a         (a1),
    .b         (b1),
    .out_valid (ov1),
    .out_ready (or1),
    .result    (r1),
    .borrow    (bo1),
    .overflow  (of1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic void expect_of(
    input  int         sz,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] r,
    output logic       bo,
    output logic       ov);
    int m, ai, bi, sa, sb, sd;
    m  = 1 << sz;
    ai = int'(a);
    bi = int'(b);
    r  = 8'((ai - bi + m) % m);
    bo = (ai < bi);
    sa = (ai >= m / 2) ? ai - m : ai;
    sb = (bi >= m / 2) ? bi - m : bi;
    sd = sa - sb;
    ov = (sd < -(m / 2)) || (sd >= m / 2);
  endfunction

  task automatic mstep(input int k, input int sz,
                       input logic iv, input logic ir,
                       input logic vld, input logic ordy,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] r,
                       input logic bo, input logic ofl);
    logic ev;
    logic acc;
    string p;
    p = $sformatf("m%0d_", sz);
    if (!rst_n) begin
      pend[k] = 1'b0;
      vr[k] = '0;
      vb[k] = 1'b0;
      vo[k] = 1'b0;
      chk({p, "rst_valid"}, vld, 1'b0);
      chk({p, "rst_ready"}, ir, 1'b1);
      chk({p, "rst_result"}, r, 8'h00);
      chk({p, "rst_flags"}, {bo, ofl}, 2'b00);
    end else begin
      ev = pend[k] && (cyc >= rdy[k]);
      if (ev) begin
        vr[k] = er[k];
        vb[k] = eb[k];
        vo[k] = eo[k];
      end
      chk({p, "in_ready"}, ir, !pend[k]);
      chk({p, "out_valid"}, vld, ev);
      chk({p, "result"}, r, vr[k]);
      chk({p, "borrow"}, bo, vb[k]);
      chk({p, "overflow"}, ofl, vo[k]);
      acc = iv && !pend[k];
      if (ev && ordy) pend[k] = 1'b0;
      if (acc) begin
        expect_of(sz, a, b, er[k], eb[k], eo[k]);
        pend[k] = 1'b1;
        rdy[k] = cyc + sz + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    mstep(0, 8, iv8, ir8, ov8, or8, a8, b8,
          r8, bo8, of8);
    mstep(1, 1, iv1, ir1, ov1, or1,
          {7'b0, a1}, {7'b0, b1}, {7'b0, r1},
          bo1, of1);
    cyc++;
  end

  function automatic logic cur_valid(input int k);
    return (k == 0) ? ov8 : ov1;
  endfunction

  task automatic op(input int k,
                    input logic [7:0] a,
                    input logic [7:0] b,
                    input logic [7:0] r,
                    input logic bo, input logic ofl);
    int n;
    int sz;
    logic v;
    sz = (k == 0) ? 8 : 1;
    @(posedge clk); #1;
    if (k == 0) begin
      a8 = a; b8 = b; iv8 = 1'b1;
    end else begin
      a1 = a[0]; b1 = b[0]; iv1 = 1'b1;
    end
    n = 0;
    v = 1'b0;
    while (!v && n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        iv8 = 1'b0;
        iv1 = 1'b0;
      end
      v = cur_valid(k);
    end
    chk($sformatf("lat_%0h_%0h", a, b), n, sz + 1);
    if (k == 0) begin
      chk($sformatf("res_%0h_%0h", a, b), r8, r);
      chk($sformatf("flg_%0h_%0h", a, b),
          {bo8, of8}, {bo, ofl});
      or8 = 1'b1;
    end else begin
      chk($sformatf("res1_%0h_%0h", a, b), r1, r[0]);
      chk($sformatf("flg1_%0h_%0h", a, b),
          {bo1, of1}, {bo, ofl});
      or1 = 1'b1;
    end
    @(posedge clk); #1;
    or8 = 1'b0;
    or1 = 1'b0;
    chk("drop_valid", cur_valid(k), 1'b0);
    chk("back_idle", (k == 0) ? ir8 : ir1, 1'b1);
  endtask

  task automatic wait_valid8(input string nm);
    int n;
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) iv8 = 1'b0;
    end
    chk(nm, ov8, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid8", ov8, 1'b0);
    chk("reset_ready8", ir8, 1'b1);
    chk("reset_result8", r8, 8'h00);
    chk("reset_valid1", ov1, 1'b0);
    rst_n = 1'b1;

    op(0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op(0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op(0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op(0, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    @(posedge clk); #1;
    a8 = 8'h09; b8 = 8'h04; iv8 = 1'b1;
    wait_valid8("stall_reach_done");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      iv8 = 1'b1;
      chk("stall_valid", ov8, 1'b1);
      chk("stall_ready", ir8, 1'b0);
      chk("stall_result", r8, 8'h05);
    end
    a8 = 8'h10; b8 = 8'h20; iv8 = 1'b1;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("handoff_valid", ov8, 1'b0);
    chk("handoff_idle", ir8, 1'b1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("next_accepted", ir8, 1'b0);
    wait_valid8("next_done");
    chk("next_result", r8, 8'hF0);
    chk("next_flags", {bo8, of8}, 2'b10);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;

    a8 = 8'h55; b8 = 8'h11; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_valid", ov8, 1'b0);
    chk("midrun_ready", ir8, 1'b1);
    chk("midrun_result", r8, 8'h00);
    chk("midrun_flags", {bo8, of8}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    op(1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    op(1, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1);
    op(1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0);
    op(1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
